axil_mem_arbiter: RTL and testbench
===================================

Name: axil_mem_arbiter

Overview:
- Two-master, one-slave AXI-Lite arbiter that shares the single memory slave between the instruction fetch unit (IFU, read-only) and the load/store unit (LSU, read and write).
- Sits between the IFU/LSU and the memory. Holds one outstanding transaction at a time.
- Grants round-robin between the two masters and routes the winner's channels to the slave until its response handshake completes.

Parameters:
AW, 32, address width on all ports
DW, 32, data width on all ports

Ports:
clk  in  1  clock
rst  in  1  reset
ifu_araddr/ifu_arvalid  in  AW/1  IFU read address
ifu_arready  out  1  IFU read address ready
ifu_rdata/ifu_rresp/ifu_rvalid  out  DW/2/1  IFU read data channel
ifu_rready  in  1  IFU read data ready
lsu_araddr/lsu_arvalid  in  AW/1  LSU read address
lsu_arready  out  1  LSU read address ready
lsu_rdata/lsu_rresp/lsu_rvalid  out  DW/2/1  LSU read data channel
lsu_rready  in  1  LSU read data ready
lsu_awaddr/lsu_awvalid, lsu_wdata/lsu_wstrb/lsu_wvalid  in  AW/1, DW/4/1  LSU write address/data
lsu_awready/lsu_wready  out  1/1  LSU write address/data ready
lsu_bresp/lsu_bvalid  out  2/1  LSU write response
lsu_bready  in  1  LSU write response ready
s_araddr/s_arvalid, s_rready  out  AW/1, 1  slave read request side
s_arready, s_rdata/s_rresp/s_rvalid  in  1, DW/2/1  slave read return side
s_awaddr/s_awvalid/s_wdata/s_wstrb/s_wvalid, s_bready  out  AW/1/DW/4/1, 1  slave write request side
s_awready/s_wready, s_bresp/s_bvalid  in  1/1, 2/1  slave write return side

Behaviour:
- Reset rst is synchronous, active-low; clock clk.
- On reset: state=IDLE, last_grant=LSU (so IFU wins the first tie).
- While in IDLE, every master-facing valid/ready and every slave-facing valid/ready is 0.
- States:
  - IDLE
  - G_IFU_R: IFU read granted
  - G_LSU_R: LSU read granted
  - G_LSU_W: LSU write granted
- Request detection, evaluated in IDLE from registered-free inputs:
  - ifu_req = ifu_arvalid
  - lsu_wreq = lsu_awvalid && lsu_wvalid
  - lsu_rreq = lsu_arvalid && !lsu_wreq (a simultaneous LSU write wins over an LSU read)
  - lsu_req = lsu_wreq || lsu_rreq
- IDLE transitions:
  - Only one master requesting: grant it.
  - Both requesting: grant the master != last_grant, then update last_grant.
  - No request: stay in IDLE.
  - lsu_awvalid without lsu_wvalid is not a request; wait.
- Grant is registered. A request seen in cycle N is first forwarded to the slave in cycle N+1. The arbiter adds exactly 1 cycle of request latency.
- Routing in G_*: the granted master's channels connect combinationally to the slave, with zero added latency on data and response paths.
  - s_ar*/s_aw*/s_w* take the granted master's values; s_rready/s_bready take the granted master's ready.
  - The granted master receives the slave's arready/awready/wready/rdata/rresp/rvalid/bresp/bvalid.
  - Non-granted masters see all ready/valid = 0. Their data/resp outputs are don't-care, driven 0.
  - Slave channels unused by the current grant have valid = 0.
- Completion and return to IDLE:
  - G_*_R returns to IDLE on the cycle after s_rvalid && s_rready.
  - G_LSU_W returns to IDLE on the cycle after s_bvalid && s_bready.
  - IDLE always lasts at least 1 cycle between grants. Back-to-back throughput is therefore one transaction per (slave latency + 2) cycles.
- A granted master must hold its valid until accepted (AXI rule). The arbiter never drops a grant before the response handshake, even if the master deasserts valid.
- Reset asserted mid-transaction: the arbiter returns to IDLE and all outputs go to 0 the next cycle. The slave is reset by the same rst.
- Response codes (rresp/bresp) pass through unmodified.
- No arbiter-generated errors.

Test Plan:
- Single IFU read: after reset, ifu_araddr=0x80000000 with arvalid held. Required: s_arvalid=1 one cycle later with s_araddr=0x80000000. After the slave returns rdata=0x00000413, ifu_rvalid=1, ifu_rdata=0x00000413, rresp=00, and lsu_rvalid stays 0 throughout.
- Simultaneous reads, IFU@0x80000000 and LSU@0x80001000, arriving in the same cycle from reset. Required: IFU granted first. LSU is forwarded only after IFU's r handshake plus 1 IDLE cycle. In a repeat of the tie, LSU is granted first (round-robin).
- LSU write: awaddr=0x80002000, wdata=0xDEADBEEF, wstrb=4'b0011, awvalid=wvalid=1. Required: s_awvalid=s_wvalid=1 with the same values one cycle later, lsu_bvalid=1 with bresp=00 on slave bvalid, and the IFU blocked (ifu_arready=0) during the write.
- LSU asserts arvalid and awvalid/wvalid in the same cycle. Required: write granted, and lsu_arready=0 until the next grant, which serves the LSU read.
- Slave delays rvalid 8 cycles while ifu_rready is held 0 for 3 extra cycles. Required: state stays G_IFU_R, and no LSU request is forwarded until the handshake completes.
- rst pulled low 2 cycles after a grant. Required: the next cycle has all valid/ready outputs at 0, and the first post-reset tie goes to the IFU.

Source files
------------

// File: rtl/axil_mem_arbiter_if.sv
// AXI-Lite channel bundle shared by the arbiter's IFU, LSU and memory-side ports.
// master drives address/data/ready-for-response; slave drives accept-ready and responses.
interface axil_mem_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic [AW-1:0]   awaddr;
  logic            awvalid;
  logic            awready;
  logic [DW-1:0]   wdata;
  logic [DW/8-1:0] wstrb;
  logic            wvalid;
  logic            wready;
  logic [1:0]      bresp;
  logic            bvalid;
  logic            bready;
  logic [AW-1:0]   araddr;
  logic            arvalid;
  logic            arready;
  logic [DW-1:0]   rdata;
  logic [1:0]      rresp;
  logic            rvalid;
  logic            rready;

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/axil_mem_arbiter.sv
// Round-robin AXI-Lite arbiter: IFU (read-only) and LSU (read/write) share one memory slave,
// one transaction in flight; grant is registered, routing while granted is combinational.
module axil_mem_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic              clk,
  input  logic              rst,
  axil_mem_arbiter_if.slave  ifu_bus,
  axil_mem_arbiter_if.slave  lsu_bus,
  axil_mem_arbiter_if.master s_bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    G_IFU_R = 2'd1,
    G_LSU_R = 2'd2,
    G_LSU_W = 2'd3
  } state_t;

  localparam logic GRANT_IFU = 1'b0;
  localparam logic GRANT_LSU = 1'b1;

  state_t r_state;
  state_t w_state_nxt;
  state_t w_lsu_target;
  logic   r_last_grant;
  logic   w_last_grant_nxt;
  logic   w_ifu_req;
  logic   w_lsu_wreq;
  logic   w_lsu_rreq;
  logic   w_lsu_req;
  logic   w_unused_ifu_wr;

  assign w_ifu_req    = ifu_bus.arvalid;
  assign w_lsu_wreq   = lsu_bus.awvalid && lsu_bus.wvalid;
  assign w_lsu_rreq   = lsu_bus.arvalid && !w_lsu_wreq;
  assign w_lsu_req    = w_lsu_wreq || w_lsu_rreq;
  assign w_lsu_target = w_lsu_wreq ? G_LSU_W : G_LSU_R;

  // The IFU never writes; its write-request fields are sunk here.
  assign w_unused_ifu_wr = ^{ifu_bus.awaddr, ifu_bus.awvalid, ifu_bus.wdata,
                             ifu_bus.wstrb, ifu_bus.wvalid, ifu_bus.bready};

  // Grant state and round-robin pointer
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state      <= IDLE;
      r_last_grant <= GRANT_LSU;
    end else begin
      r_state      <= w_state_nxt;
      r_last_grant <= w_last_grant_nxt;
    end
  end

  // Arbitration and completion; the pointer only moves when both masters contend
  always_comb begin
    w_state_nxt      = r_state;
    w_last_grant_nxt = r_last_grant;
    case (r_state)
      IDLE: begin
        if (w_ifu_req && w_lsu_req) begin
          if (r_last_grant == GRANT_LSU) begin
            w_state_nxt      = G_IFU_R;
            w_last_grant_nxt = GRANT_IFU;
          end else begin
            w_state_nxt      = w_lsu_target;
            w_last_grant_nxt = GRANT_LSU;
          end
        end else if (w_ifu_req) begin
          w_state_nxt = G_IFU_R;
        end else if (w_lsu_req) begin
          w_state_nxt = w_lsu_target;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      G_IFU_R: begin
        if (s_bus.rvalid && ifu_bus.rready) begin
          w_state_nxt = IDLE;
        end else begin
          w_state_nxt = G_IFU_R;
        end
      end
      G_LSU_R: begin
        if (s_bus.rvalid && lsu_bus.rready) begin
          w_state_nxt = IDLE;
        end else begin
          w_state_nxt = G_LSU_R;
        end
      end
      G_LSU_W: begin
        if (s_bus.bvalid && lsu_bus.bready) begin
          w_state_nxt = IDLE;
        end else begin
          w_state_nxt = G_LSU_W;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Channel routing: everything idles at zero unless the current grant connects it
  always_comb begin
    s_bus.awaddr    = {AW{1'b0}};
    s_bus.awvalid   = 1'b0;
    s_bus.wdata     = {DW{1'b0}};
    s_bus.wstrb     = {(DW/8){1'b0}};
    s_bus.wvalid    = 1'b0;
    s_bus.bready    = 1'b0;
    s_bus.araddr    = {AW{1'b0}};
    s_bus.arvalid   = 1'b0;
    s_bus.rready    = 1'b0;
    ifu_bus.awready = 1'b0;
    ifu_bus.wready  = 1'b0;
    ifu_bus.bresp   = 2'b00;
    ifu_bus.bvalid  = 1'b0;
    ifu_bus.arready = 1'b0;
    ifu_bus.rdata   = {DW{1'b0}};
    ifu_bus.rresp   = 2'b00;
    ifu_bus.rvalid  = 1'b0;
    lsu_bus.awready = 1'b0;
    lsu_bus.wready  = 1'b0;
    lsu_bus.bresp   = 2'b00;
    lsu_bus.bvalid  = 1'b0;
    lsu_bus.arready = 1'b0;
    lsu_bus.rdata   = {DW{1'b0}};
    lsu_bus.rresp   = 2'b00;
    lsu_bus.rvalid  = 1'b0;
    case (r_state)
      G_IFU_R: begin
        s_bus.araddr    = ifu_bus.araddr;
        s_bus.arvalid   = ifu_bus.arvalid;
        s_bus.rready    = ifu_bus.rready;
        ifu_bus.arready = s_bus.arready;
        ifu_bus.rdata   = s_bus.rdata;
        ifu_bus.rresp   = s_bus.rresp;
        ifu_bus.rvalid  = s_bus.rvalid;
      end
      G_LSU_R: begin
        s_bus.araddr    = lsu_bus.araddr;
        s_bus.arvalid   = lsu_bus.arvalid;
        s_bus.rready    = lsu_bus.rready;
        lsu_bus.arready = s_bus.arready;
        lsu_bus.rdata   = s_bus.rdata;
        lsu_bus.rresp   = s_bus.rresp;
        lsu_bus.rvalid  = s_bus.rvalid;
      end
      G_LSU_W: begin
        s_bus.awaddr    = lsu_bus.awaddr;
        s_bus.awvalid   = lsu_bus.awvalid;
        s_bus.wdata     = lsu_bus.wdata;
        s_bus.wstrb     = lsu_bus.wstrb;
        s_bus.wvalid    = lsu_bus.wvalid;
        s_bus.bready    = lsu_bus.bready;
        lsu_bus.awready = s_bus.awready;
        lsu_bus.wready  = s_bus.wready;
        lsu_bus.bresp   = s_bus.bresp;
        lsu_bus.bvalid  = s_bus.bvalid;
      end
      default: begin
        s_bus.arvalid = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_axil_mem_arbiter.sv
// Bench for axil_mem_arbiter: arbitration decision table, then multi-cycle sequences
// against a latency-configurable slave model with response scoreboards per master.
module tb_axil_mem_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam logic [31:0] A_IFU = 32'h8000_0000;
  localparam logic [31:0] A_LSU = 32'h8000_1000;
  localparam logic [31:0] A_WR  = 32'h8000_2000;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  int   slv_lat = 1;

  logic [33:0] ifu_q[$];
  logic [33:0] lsu_rq[$];
  logic [1:0]  lsu_bq[$];

  axil_mem_arbiter_if #(.AW(AW), .DW(DW)) ifu_if ();
  axil_mem_arbiter_if #(.AW(AW), .DW(DW)) lsu_if ();
  axil_mem_arbiter_if #(.AW(AW), .DW(DW)) s_if ();

  axil_mem_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk     (clk),
    .rst     (rst),
    .ifu_bus (ifu_if),
    .lsu_bus (lsu_if),
    .s_bus   (s_if)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    string      name;
    logic       ifu_ar;
    logic       lsu_ar;
    logic       lsu_aw;
    logic       lsu_w;
    logic [2:0] exp_sv;   // {s_arvalid, s_awvalid, s_wvalid}
    logic [2:0] exp_rdy;  // {ifu_arready, lsu_arready, lsu_awready}
    logic [31:0] exp_addr;
  } vec_t;
  vec_t vt[10];

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: wait bound expired at cycle %0d", name, cyc);
  endtask

  function automatic logic [31:0] slv_data(input logic [31:0] a);
    if (a == 32'h8000_0000) return 32'h0000_0413;
    return a ^ 32'h5A5A_0000;
  endfunction

  function automatic logic [1:0] slv_resp(input logic [31:0] a);
    return (a[15:12] == 4'h1) ? 2'b01 : 2'b00;
  endfunction

  function automatic logic [11:0] all_vr();
    return {s_if.arvalid, s_if.awvalid, s_if.wvalid, s_if.rready, s_if.bready,
            ifu_if.arready, ifu_if.rvalid, lsu_if.arready, lsu_if.awready,
            lsu_if.wready, lsu_if.rvalid, lsu_if.bvalid};
  endfunction

  // Slave model: always ready for requests, answers after slv_lat cycles, aborts on reset
  initial begin : slave_model
    logic [31:0] a;
    bit rd;
    bit alive;
    s_if.arready = 1'b1; s_if.awready = 1'b1; s_if.wready = 1'b1;
    s_if.rvalid = 1'b0; s_if.rdata = 32'h0; s_if.rresp = 2'b00;
    s_if.bvalid = 1'b0; s_if.bresp = 2'b00;
    forever begin
      @(negedge clk);
      rd = s_if.arvalid && s_if.arready;
      if (rst && (rd || (s_if.awvalid && s_if.wvalid))) begin
        a = rd ? s_if.araddr : s_if.awaddr;
        alive = 1'b1;
        for (int k = 0; k < slv_lat && alive; k++) begin
          @(posedge clk);
          if (!rst) alive = 1'b0;
        end
        if (alive) begin
          #1;
          if (rd) begin
            s_if.rvalid = 1'b1; s_if.rdata = slv_data(a); s_if.rresp = slv_resp(a);
          end else begin
            s_if.bvalid = 1'b1; s_if.bresp = 2'b00;
          end
          for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (!rst || (rd && s_if.rready) || (!rd && s_if.bready)) break;
          end
          @(posedge clk); #1;
          s_if.rvalid = 1'b0; s_if.bvalid = 1'b0;
        end
      end
    end
  end

  // Response scoreboards and cross-master exclusivity
  always @(negedge clk) begin
    if (rst) begin
      if (ifu_if.rvalid && ifu_q.size() == 0) timeout("ifu_rvalid_unexpected");
      if (lsu_if.rvalid && lsu_rq.size() == 0) timeout("lsu_rvalid_unexpected");
      if (lsu_if.bvalid && lsu_bq.size() == 0) timeout("lsu_bvalid_unexpected");
      if (ifu_if.rvalid && lsu_if.rvalid) timeout("both_rvalid");
      if (ifu_if.rvalid && ifu_if.rready && ifu_q.size() != 0)
        check("ifu_r", {ifu_if.rresp, ifu_if.rdata}, ifu_q.pop_front());
      if (lsu_if.rvalid && lsu_if.rready && lsu_rq.size() != 0)
        check("lsu_r", {lsu_if.rresp, lsu_if.rdata}, lsu_rq.pop_front());
      if (lsu_if.bvalid && lsu_if.bready && lsu_bq.size() != 0)
        check("lsu_b", lsu_if.bresp, lsu_bq.pop_front());
    end
  end

  task automatic clear_masters();
    ifu_if.arvalid = 1'b0; ifu_if.araddr = 32'h0; ifu_if.rready = 1'b0;
    lsu_if.arvalid = 1'b0; lsu_if.araddr = 32'h0; lsu_if.rready = 1'b0;
    lsu_if.awvalid = 1'b0; lsu_if.awaddr = 32'h0; lsu_if.wvalid = 1'b0;
    lsu_if.wdata = 32'h0; lsu_if.wstrb = 4'h0; lsu_if.bready = 1'b0;
  endtask

  task automatic reset_dut();
    @(posedge clk); #1;
    rst = 1'b0;
    clear_masters();
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  task automatic read_txn(input bit use_lsu, input logic [31:0] addr, input int rdy_dly,
                          output int t0, output int tg, output int th);
    bit ok;
    @(posedge clk); #1;
    t0 = cyc;
    if (use_lsu) begin
      lsu_if.araddr = addr; lsu_if.arvalid = 1'b1; lsu_if.rready = (rdy_dly == 0);
      lsu_rq.push_back({slv_resp(addr), slv_data(addr)});
    end else begin
      ifu_if.araddr = addr; ifu_if.arvalid = 1'b1; ifu_if.rready = (rdy_dly == 0);
      ifu_q.push_back({slv_resp(addr), slv_data(addr)});
    end
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (use_lsu ? lsu_if.arready : ifu_if.arready) begin ok = 1'b1; break; end
    end
    tg = cyc;
    if (!ok) timeout("ar_grant");
    else check("rd_fwd", {s_if.arvalid, s_if.awvalid, s_if.araddr}, {1'b1, 1'b0, addr});
    @(posedge clk); #1;
    if (use_lsu) lsu_if.arvalid = 1'b0; else ifu_if.arvalid = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (use_lsu ? lsu_if.rvalid : ifu_if.rvalid) begin ok = 1'b1; break; end
    end
    if (!ok) timeout("rvalid_wait");
    if (rdy_dly > 0) begin
      repeat (rdy_dly) @(posedge clk);
      #1;
      if (use_lsu) lsu_if.rready = 1'b1; else ifu_if.rready = 1'b1;
      @(negedge clk);
    end
    th = cyc;
    if (!(use_lsu ? (lsu_if.rvalid && lsu_if.rready) : (ifu_if.rvalid && ifu_if.rready)))
      timeout("r_handshake");
    @(posedge clk); #1;
    if (use_lsu) lsu_if.rready = 1'b0; else ifu_if.rready = 1'b0;
  endtask

  task automatic write_txn(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           output int t0, output int tg, output int th);
    bit ok;
    @(posedge clk); #1;
    t0 = cyc;
    lsu_if.awaddr = addr; lsu_if.awvalid = 1'b1;
    lsu_if.wdata = data; lsu_if.wstrb = strb; lsu_if.wvalid = 1'b1; lsu_if.bready = 1'b1;
    lsu_bq.push_back(2'b00);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (lsu_if.awready && lsu_if.wready) begin ok = 1'b1; break; end
    end
    tg = cyc;
    if (!ok) timeout("aw_grant");
    else check("wr_fwd", {s_if.arvalid, s_if.awvalid, s_if.wvalid, s_if.awaddr, s_if.wdata, s_if.wstrb},
               {1'b0, 1'b1, 1'b1, addr, data, strb});
    @(posedge clk); #1;
    lsu_if.awvalid = 1'b0; lsu_if.wvalid = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (lsu_if.bvalid && lsu_if.bready) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    th = cyc;
    if (!ok) timeout("b_handshake");
    @(posedge clk); #1;
    lsu_if.bready = 1'b0;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int it0, ig, ih, lt0, lg, lh, wt0, wg, wh;
    ifu_if.awaddr = 32'h0; ifu_if.awvalid = 1'b0; ifu_if.wdata = 32'h0;
    ifu_if.wstrb = 4'h0; ifu_if.wvalid = 1'b0; ifu_if.bready = 1'b0;
    clear_masters();

    vt[0] = '{"none",        1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 3'b000, 32'h0};
    vt[1] = '{"ifu_rd",      1'b1, 1'b0, 1'b0, 1'b0, 3'b100, 3'b100, A_IFU};
    vt[2] = '{"lsu_rd",      1'b0, 1'b1, 1'b0, 1'b0, 3'b100, 3'b010, A_LSU};
    vt[3] = '{"lsu_wr",      1'b0, 1'b0, 1'b1, 1'b1, 3'b011, 3'b001, 32'h0};
    vt[4] = '{"aw_only",     1'b0, 1'b0, 1'b1, 1'b0, 3'b000, 3'b000, 32'h0};
    vt[5] = '{"w_only",      1'b0, 1'b0, 1'b0, 1'b1, 3'b000, 3'b000, 32'h0};
    vt[6] = '{"tie_rd",      1'b1, 1'b1, 1'b0, 1'b0, 3'b100, 3'b100, A_IFU};
    vt[7] = '{"tie_wr",      1'b1, 1'b0, 1'b1, 1'b1, 3'b100, 3'b100, A_IFU};
    vt[8] = '{"lsu_rw",      1'b0, 1'b1, 1'b1, 1'b1, 3'b011, 3'b001, 32'h0};
    vt[9] = '{"lsu_rd_awonly", 1'b0, 1'b1, 1'b1, 1'b0, 3'b100, 3'b010, A_LSU};

    reset_dut();
    @(negedge clk);
    check("reset_outputs", all_vr(), 12'h000);

    slv_lat = 6;
    for (int i = 0; i < 10; i++) begin
      reset_dut();
      @(posedge clk); #1;
      ifu_if.araddr = A_IFU; lsu_if.araddr = A_LSU; lsu_if.awaddr = A_WR;
      lsu_if.wdata = 32'h1234_5678; lsu_if.wstrb = 4'hF;
      ifu_if.arvalid = vt[i].ifu_ar; lsu_if.arvalid = vt[i].lsu_ar;
      lsu_if.awvalid = vt[i].lsu_aw; lsu_if.wvalid = vt[i].lsu_w;
      @(negedge clk);
      check({vt[i].name, "_idle"}, {s_if.arvalid, s_if.awvalid, s_if.wvalid}, 3'b000);
      @(negedge clk);
      check({vt[i].name, "_sv"}, {s_if.arvalid, s_if.awvalid, s_if.wvalid}, vt[i].exp_sv);
      check({vt[i].name, "_rdy"}, {ifu_if.arready, lsu_if.arready, lsu_if.awready}, vt[i].exp_rdy);
      if (vt[i].exp_sv[2]) check({vt[i].name, "_addr"}, s_if.araddr, vt[i].exp_addr);
    end

    // Single IFU read
    slv_lat = 1;
    reset_dut();
    read_txn(1'b0, A_IFU, 0, it0, ig, ih);
    check("ifu_req_latency", ig - it0, 1);
    check("ifu_resp_latency", ih - ig, 1);

    // Tie from reset goes to IFU, repeat tie goes to LSU
    reset_dut();
    fork
      read_txn(1'b0, A_IFU, 0, it0, ig, ih);
      read_txn(1'b1, A_LSU, 0, lt0, lg, lh);
    join
    check("tie1_ifu_first", ig - it0, 1);
    check("tie1_lsu_after_idle", lg - ih, 2);
    fork
      read_txn(1'b0, A_IFU, 0, it0, ig, ih);
      read_txn(1'b1, A_LSU, 0, lt0, lg, lh);
    join
    check("tie2_lsu_first", lg - lt0, 1);
    check("tie2_ifu_after_idle", ig - lh, 2);

    // LSU write with IFU arriving while the write is granted
    fork
      write_txn(A_WR, 32'hDEAD_BEEF, 4'b0011, wt0, wg, wh);
      begin
        @(posedge clk);
        read_txn(1'b0, A_IFU, 0, it0, ig, ih);
      end
    join
    check("wr_req_latency", wg - wt0, 1);
    check("wr_blocks_ifu", ig - wh, 2);

    // Simultaneous LSU read and write: write wins, read follows
    fork
      write_txn(A_WR, 32'hCAFE_0001, 4'b1100, wt0, wg, wh);
      read_txn(1'b1, A_LSU, 0, lt0, lg, lh);
    join
    check("lsu_rw_write_first", wg - wt0, 1);
    check("lsu_rw_read_next", lg - wh, 2);

    // Slow slave plus IFU back-pressure holds the grant
    slv_lat = 8;
    fork
      read_txn(1'b0, A_IFU, 3, it0, ig, ih);
      begin
        @(posedge clk);
        read_txn(1'b1, A_LSU, 0, lt0, lg, lh);
      end
    join
    check("slow_hold_grant", ih - ig, 11);
    check("slow_lsu_waits", lg - ih, 2);

    // Reset two cycles after a grant, then first tie goes to IFU
    slv_lat = 1;
    reset_dut();
    fork
      read_txn(1'b0, A_IFU, 0, it0, ig, ih);
      read_txn(1'b1, A_LSU, 0, lt0, lg, lh);
    join
    slv_lat = 8;
    @(posedge clk); #1;
    ifu_if.araddr = A_IFU; ifu_if.arvalid = 1'b1; ifu_if.rready = 1'b1;
    begin : wait_grant
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 100; i++) begin
        @(negedge clk);
        if (ifu_if.arready) begin ok = 1'b1; break; end
      end
      if (!ok) timeout("rst_case_grant");
    end
    @(posedge clk); #1;
    ifu_if.arvalid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("pre_reset_still_granted", s_if.rready, 1'b1);
    @(negedge clk);
    check("mid_txn_reset_outputs", all_vr(), 12'h000);
    @(posedge clk); #1;
    rst = 1'b1;
    ifu_if.rready = 1'b0;
    slv_lat = 1;
    fork
      read_txn(1'b0, A_IFU, 0, it0, ig, ih);
      read_txn(1'b1, A_LSU, 0, lt0, lg, lh);
    join
    check("post_reset_tie_ifu", ig - it0, 1);
    check("post_reset_tie_lsu", lg - ih, 2);

    repeat (3) @(posedge clk);
    check("scoreboards_drained", {ifu_q.size(), lsu_rq.size(), lsu_bq.size()}, 96'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
